// File: rtl/pong_engine.sv
// pong_engine: Pong game core. Paddle positions, ball kinematics with
// five-zone paddle reflection, scoring and match FSM, all on CLOCK_25 and
// advanced by a one-cycle frame-rate tick.
// Optional feature macro: PONG_CPU_PLAYER_EN. When defined, paddle 2 tracks
// the ball on each tick and p2_up/p2_down are ignored.
module pong_engine #(
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 60,
  parameter int BALL_S      = 8,
  parameter int P1_X        = 16,
  parameter int P2_X        = 616,
  parameter int PADDLE_STEP = 8,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60
) (
  input  logic        CLOCK_25,
  input  logic        RESET,
  input  logic        tick,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic        btn_continue,
  input  logic        btn_pause,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [11:0] p1_y,
  output logic [11:0] p2_y,
  output logic [3:0]  score_1,
  output logic [3:0]  score_2,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic        point_pulse
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_PAUSED = 3'd2,
    S_POINT  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY - 1);

  // Unsigned position constants (register domain)
  localparam logic [11:0] BALL_X0   = 12'((FRAME_W - BALL_S) / 2);
  localparam logic [11:0] BALL_Y0   = 12'((FRAME_H - BALL_S) / 2);
  localparam logic [11:0] PAD_Y0    = 12'((FRAME_H - PADDLE_H) / 2);
  localparam logic [11:0] PAD_YMAX  = 12'(FRAME_H - PADDLE_H);
  localparam logic [11:0] STEP      = 12'(PADDLE_STEP);
  localparam logic [11:0] P1_EDGE_U = 12'(P1_X + PADDLE_W);
  localparam logic [11:0] P2_EDGE_U = 12'(P2_X - BALL_S);
  localparam logic [11:0] BX_MAX_U  = 12'(FRAME_W - BALL_S);
  localparam logic [11:0] BY_MAX_U  = 12'(FRAME_H - BALL_S);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

  // Signed 13-bit constants for the kinematics compare path
  localparam logic signed [12:0] P1_EDGE   = 13'(P1_X + PADDLE_W);
  localparam logic signed [12:0] P2_EDGE   = 13'(P2_X - BALL_S);
  localparam logic signed [12:0] BX_MAX    = 13'(FRAME_W - BALL_S);
  localparam logic signed [12:0] BY_MAX    = 13'(FRAME_H - BALL_S);
  localparam logic signed [12:0] BALL_SS   = 13'(BALL_S);
  localparam logic signed [12:0] BALL_HALF = 13'(BALL_S / 2);
  localparam logic signed [12:0] PAD_HS    = 13'(PADDLE_H);
  localparam logic [12:0]        ZONE_HU   = 13'(PADDLE_H / 5);

  state_t state_q, state_d;

  logic          dir_r, dir_d, serve_left;
  logic [2:0]    dx_q, dy_q;
  logic [CW-1:0] serve_cnt;

  logic signed [12:0] bxs, bys, p1s, p2s, pzs, dxs, dys, nx, ny, zoff;
  logic [11:0]        ny_w;
  logic               dird_w, hit1, hit2, hit, miss_l, miss_r, win, go;
  logic [12:0]        zq;
  logic [2:0]         zone, zdx, zdy;
  logic [3:0]         s1_inc, s2_inc;
  logic               pad_en, step_en, serve_en, clear_en;

`ifdef PONG_CPU_PLAYER_EN
  localparam logic signed [12:0] PAD_HALF  = 13'(PADDLE_H / 2);
  localparam logic signed [12:0] HALF_STEP = 13'(PADDLE_STEP / 2);
  logic signed [12:0] cpu_dlt;
  logic               cpu_up, cpu_dn;
  logic               unused_p2;
  assign unused_p2 = p2_up | p2_down;
`endif

  assign go = btn_continue && !btn_pause;

  // Clamped paddle step; up and down together cancel.
  function automatic logic [11:0] pad_move(input logic [11:0] y, input logic up,
                                           input logic dn);
    pad_move = y;
    if (up && !dn)      pad_move = (y < STEP) ? 12'd0 : y - STEP;
    else if (dn && !up) pad_move = (y + STEP > PAD_YMAX) ? PAD_YMAX : y + STEP;
  endfunction

  // Candidate ball step: walls, paddle crossings, zone and miss detection.
  always_comb begin
    bxs = signed'({1'b0, ball_x});
    bys = signed'({1'b0, ball_y});
    p1s = signed'({1'b0, p1_y});
    p2s = signed'({1'b0, p2_y});
    dxs = signed'({10'd0, dx_q});
    dys = signed'({10'd0, dy_q});
    nx  = dir_r ? bxs + dxs : bxs - dxs;
    ny  = dir_d ? bys + dys : bys - dys;

    ny_w   = ny[11:0];
    dird_w = dir_d;
    if (ny <= 13'sd0) begin
      ny_w   = 12'd0;
      dird_w = 1'b1;
    end else if (ny >= BY_MAX) begin
      ny_w   = BY_MAX_U;
      dird_w = 1'b0;
    end

    hit1 = !dir_r && (bxs >= P1_EDGE) && (nx < P1_EDGE) &&
           (bys + BALL_SS > p1s) && (bys < p1s + PAD_HS);
    hit2 = dir_r && (bxs <= P2_EDGE) && (nx > P2_EDGE) &&
           (bys + BALL_SS > p2s) && (bys < p2s + PAD_HS);
    hit    = hit1 | hit2;
    miss_l = !hit && (nx <= 13'sd0);
    miss_r = !hit && (nx >= BX_MAX);

    // Zone of the paddle the ball is travelling toward
    pzs  = dir_r ? p2s : p1s;
    zoff = bys + BALL_HALF - pzs;
    if (zoff < 13'sd0) zq = 13'd0;
    else               zq = unsigned'(zoff) / ZONE_HU;
    zone = (zq > 13'd4) ? 3'd4 : zq[2:0];
    case (zone)
      3'd0, 3'd4: begin zdx = 3'd2; zdy = 3'd2; end
      3'd1, 3'd3: begin zdx = 3'd3; zdy = 3'd1; end
      default:    begin zdx = 3'd4; zdy = 3'd0; end
    endcase

    s1_inc = (score_1 >= WIN) ? WIN : score_1 + 4'd1;
    s2_inc = (score_2 >= WIN) ? WIN : score_2 + 4'd1;
    win    = miss_l ? (s2_inc == WIN) : (s1_inc == WIN);
  end

`ifdef PONG_CPU_PLAYER_EN
  // CPU paddle: chase the ball centre with a dead band of half a step.
  always_comb begin
    cpu_dlt = bys + BALL_HALF - PAD_HALF - p2s;
    cpu_dn  = cpu_dlt > HALF_STEP;
    cpu_up  = cpu_dlt < -HALF_STEP;
  end
`endif

  // FSM state register
  always_ff @(posedge CLOCK_25) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; pause beats continue, pause beats a same-cycle tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go) state_d = S_PLAY;
      S_PLAY: begin
        if (btn_pause)                       state_d = S_PAUSED;
        else if (tick && (miss_l || miss_r)) state_d = win ? S_OVER : S_POINT;
      end
      S_PAUSED: if (go) state_d = S_PLAY;
      S_POINT:  if (tick && (serve_cnt == SERVE_LAST)) state_d = S_PLAY;
      S_OVER:   if (go) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: datapath enables and the visible state code
  always_comb begin
    state    = state_q;
    pad_en   = (state_q == S_PLAY) || (state_q == S_POINT);
    step_en  = (state_q == S_PLAY) && tick && !btn_pause;
    serve_en = (state_q == S_POINT) && tick && (serve_cnt == SERVE_LAST);
    clear_en = (state_q == S_OVER) && go;
  end

  // Ticks spent waiting in POINT
  always_ff @(posedge CLOCK_25) begin
    if (RESET || state_q != S_POINT) serve_cnt <= '0;
    else if (tick)                   serve_cnt <= serve_cnt + 1'b1;
  end

  // Game datapath: paddles, ball, direction, scores
  always_ff @(posedge CLOCK_25) begin
    if (RESET) begin
      ball_x      <= BALL_X0;
      ball_y      <= BALL_Y0;
      p1_y        <= PAD_Y0;
      p2_y        <= PAD_Y0;
      dir_r       <= 1'b1;
      dir_d       <= 1'b1;
      dx_q        <= 3'd4;
      dy_q        <= 3'd0;
      score_1     <= 4'd0;
      score_2     <= 4'd0;
      winner      <= 2'd0;
      point_pulse <= 1'b0;
      serve_left  <= 1'b0;
    end else begin
      point_pulse <= 1'b0;

      if (pad_en) begin
        p1_y <= pad_move(p1_y, p1_up, p1_down);
`ifdef PONG_CPU_PLAYER_EN
        if (tick) p2_y <= pad_move(p2_y, cpu_up, cpu_dn);
`else
        p2_y <= pad_move(p2_y, p2_up, p2_down);
`endif
      end

      if (step_en) begin
        ball_y <= ny_w;
        dir_d  <= dird_w;
        if (hit) begin
          ball_x <= hit1 ? P1_EDGE_U : P2_EDGE_U;
          dir_r  <= hit1;
          dx_q   <= zdx;
          dy_q   <= zdy;
          // Outer zones force the vertical direction; the centre keeps it
          if (zone != 3'd2) dir_d <= (zone > 3'd2);
        end else if (miss_l || miss_r) begin
          ball_x      <= miss_l ? 12'd0 : BX_MAX_U;
          point_pulse <= 1'b1;
          serve_left  <= miss_l;
          if (miss_l) score_2 <= s2_inc;
          else        score_1 <= s1_inc;
          if (win) winner <= miss_l ? 2'd2 : 2'd1;
        end else begin
          ball_x <= nx[11:0];
        end
      end

      // Serve toward whoever conceded the last point
      if (serve_en) begin
        ball_x <= BALL_X0;
        ball_y <= BALL_Y0;
        dx_q   <= 3'd4;
        dy_q   <= 3'd0;
        dir_r  <= !serve_left;
      end

      if (clear_en) begin
        ball_x  <= BALL_X0;
        ball_y  <= BALL_Y0;
        p1_y    <= PAD_Y0;
        p2_y    <= PAD_Y0;
        dir_r   <= 1'b1;
        dir_d   <= 1'b1;
        dx_q    <= 3'd4;
        dy_q    <= 3'd0;
        score_1 <= 4'd0;
        score_2 <= 4'd0;
        winner  <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed scenarios plus randomized play, every cycle
// compared against a behavioural game model held in integer variables.
module tb_pong_engine;
  localparam int FW = 640, FH = 480, PW = 8, PH = 60, BS = 8;
  localparam int P1X = 16, P2X = 616, STEP = 8, WIN = 9, SDLY = 60;

  logic        CLOCK_25 = 1'b0;
  logic        RESET, tick, p1_up, p1_down, p2_up, p2_down, btn_continue, btn_pause;
  logic [11:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0]  score_1, score_2;
  logic [2:0]  state;
  logic [1:0]  winner;
  logic        point_pulse;

  pong_engine dut (
    .CLOCK_25(CLOCK_25), .RESET(RESET), .tick(tick),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .btn_continue(btn_continue), .btn_pause(btn_pause),
    .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .score_1(score_1), .score_2(score_2), .state(state), .winner(winner),
    .point_pulse(point_pulse)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Velocity held as signed vx, vertical speed + heading flag.
  int m_st, m_bx, m_by, m_p1, m_p2, m_vx, m_vy, m_s1, m_s2, m_win, m_wait, m_conc;
  bit m_down, m_pp;
  int ZDX[5] = '{2, 3, 4, 3, 2};
  int ZDY[5] = '{2, 1, 0, 1, 2};

  task automatic m_reset();
    m_st = 0; m_bx = (FW - BS) / 2; m_by = (FH - BS) / 2;
    m_p1 = (FH - PH) / 2; m_p2 = (FH - PH) / 2;
    m_vx = 4; m_vy = 0; m_down = 1;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_pp = 0; m_wait = 0; m_conc = 0;
  endtask

  function automatic int mv(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - STEP < 0) ? 0 : y - STEP;
    if (dn && !up) return (y + STEP > FH - PH) ? FH - PH : y + STEP;
    return y;
  endfunction

  task automatic ball_tick(input int p1o, input int p2o);
    int nx, ny, oby, off, z, pz;
    bit h1, h2;
    oby = m_by;
    nx  = m_bx + m_vx;
    ny  = m_down ? m_by + m_vy : m_by - m_vy;
    if (ny <= 0) begin ny = 0; m_down = 1; end
    else if (ny >= FH - BS) begin ny = FH - BS; m_down = 0; end
    m_by = ny;
    h1 = (m_vx < 0) && (m_bx >= P1X + PW) && (nx < P1X + PW) && (oby + BS > p1o) && (oby < p1o + PH);
    h2 = (m_vx > 0) && (m_bx <= P2X - BS) && (nx > P2X - BS) && (oby + BS > p2o) && (oby < p2o + PH);
    if (h1 || h2) begin
      pz  = h1 ? p1o : p2o;
      off = oby + BS / 2 - pz;
      z   = (off < 0) ? 0 : off / (PH / 5);
      if (z > 4) z = 4;
      m_bx = h1 ? P1X + PW : P2X - BS;
      m_vx = h1 ? ZDX[z] : -ZDX[z];
      m_vy = ZDY[z];
      if (z < 2) m_down = 0;
      else if (z > 2) m_down = 1;
    end else if (nx <= 0 || nx >= FW - BS) begin
      m_pp = 1;
      if (nx <= 0) begin
        m_bx = 0; m_conc = 1;
        m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
        if (m_s2 == WIN) m_win = 2;
      end else begin
        m_bx = FW - BS; m_conc = 2;
        m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
        if (m_s1 == WIN) m_win = 1;
      end
      if (m_win != 0) m_st = 4;
      else begin m_st = 3; m_wait = 0; end
    end else begin
      m_bx = nx;
    end
  endtask

  task automatic m_step(input bit rst, input bit tk, input bit u1, input bit d1,
                        input bit u2, input bit d2, input bit cont, input bit pse);
    int op1, op2;
    bit go;
    if (rst) begin m_reset(); return; end
    go = cont && !pse;
    m_pp = 0;
    op1 = m_p1; op2 = m_p2;
    if (m_st == 1 || m_st == 3) begin
      m_p1 = mv(op1, u1, d1);
`ifdef PONG_CPU_PLAYER_EN
      if (tk) begin
        int t;
        t = m_by + BS / 2 - PH / 2;
        if (t - op2 > STEP / 2) m_p2 = mv(op2, 0, 1);
        else if (op2 - t > STEP / 2) m_p2 = mv(op2, 1, 0);
      end
`else
      m_p2 = mv(op2, u2, d2);
`endif
    end
    case (m_st)
      0: if (go) m_st = 1;
      1: if (pse) m_st = 2; else if (tk) ball_tick(op1, op2);
      2: if (go) m_st = 1;
      3: if (tk) begin
           m_wait++;
           if (m_wait == SDLY) begin
             m_st = 1; m_bx = (FW - BS) / 2; m_by = (FH - BS) / 2;
             m_vy = 0; m_vx = (m_conc == 1) ? -4 : 4;
           end
         end
      4: if (go) m_reset();
      default: ;
    endcase
  endtask

  task automatic cmp_model();
    if (n_err > 40) return;
    chk("ball_x", ball_x, m_bx);
    chk("ball_y", ball_y, m_by);
    chk("p1_y", p1_y, m_p1);
    chk("p2_y", p2_y, m_p2);
    chk("score_1", score_1, m_s1);
    chk("score_2", score_2, m_s2);
    chk("state", state, m_st);
    chk("winner", winner, m_win);
    chk("point_pulse", point_pulse, m_pp);
  endtask

  // One clock: drive, advance model, sample 1 time unit after the edge.
  task automatic cycle(input bit rst, input bit tk, input bit u1, input bit d1,
                       input bit u2, input bit d2, input bit cont, input bit pse);
    RESET = rst; tick = tk; p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
    btn_continue = cont; btn_pause = pse;
    m_step(rst, tk, u1, d1, u2, d2, cont, pse);
    @(posedge CLOCK_25);
    #1;
    cmp_model();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, state, 0);
    chk({pfx, "_ball_x"}, ball_x, 316);
    chk({pfx, "_ball_y"}, ball_y, 236);
    chk({pfx, "_p1_y"}, p1_y, 210);
    chk({pfx, "_p2_y"}, p2_y, 210);
    chk({pfx, "_scores"}, {score_1, score_2}, 0);
    chk({pfx, "_winner"}, winner, 0);
    chk({pfx, "_pulse"}, point_pulse, 0);
  endtask

  bit r_tk, r_u1, r_d1, r_u2, r_d2, r_ct, r_ps;
  int guard, saved_bx, saved_by;

  initial begin
    {RESET, tick, p1_up, p1_down, p2_up, p2_down, btn_continue, btn_pause} = '0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk_reset_vals("rst");

    // IDLE ignores ticks
    repeat (100) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    chk("idle_state", state, 0);
    chk("idle_ball_x", ball_x, 316);
    chk("idle_ball_y", ball_y, 236);

    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("start_play", state, 1);

    // Paddle travel and clamp, no ticks so the ball stays put
    repeat (10) begin cycle(0, 0, 1, 0, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0, 0, 0, 0); end
    chk("p1_up10", p1_y, 130);
    repeat (40) begin cycle(0, 0, 1, 0, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0, 0, 0, 0); end
    chk("p1_clamp0", p1_y, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0, 0);
    chk("p1_both", p1_y, 8);
    repeat (28) cycle(0, 0, 0, 1, 0, 0, 0, 0);
    chk("p1_at232", p1_y, 232);

    // Rally: centre hit on paddle 2, then zone-0 hit on paddle 1
    repeat (74) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    chk("p2_hit_x", ball_x, 608);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    chk("p2_ret_x", ball_x, 604);
    repeat (146) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    chk("p1_hit_x", ball_x, 24);
    chk("p1_hit_y", ball_y, 236);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    chk("z0_x", ball_x, 26);
    chk("z0_y", ball_y, 234);

    // Random play until the match ends
    guard = 0;
    while (m_st != 4 && guard < 40000 && n_err <= 40) begin
      r_tk = 1'($urandom_range(0, 1));
      r_u1 = ($urandom_range(0, 15) == 0);
      r_d1 = ($urandom_range(0, 15) == 0);
      r_u2 = ($urandom_range(0, 15) == 0);
      r_d2 = ($urandom_range(0, 15) == 0);
      r_ct = ($urandom_range(0, 19) == 0);
      r_ps = ($urandom_range(0, 299) == 0);
      cycle(0, r_tk, r_u1, r_d1, r_u2, r_d2, r_ct, r_ps);
      guard++;
    end
    chk("over_state", state, 4);
    chk("over_winner", winner, (m_s1 == WIN) ? 1 : 2);
    chk("over_win_score", (m_win == 1) ? score_1 : score_2, WIN);

    // OVER: continue clears the match
    cycle(0, 1, 0, 0, 0, 0, 1, 0);
    chk_reset_vals("clear");

    // Pause beats continue; paused game is frozen
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (10) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    chk("pause_wins", state, 2);
    saved_bx = m_bx; saved_by = m_by;
    repeat (6) cycle(0, 1, 1, 0, 0, 1, 0, 0);
    chk("frozen_x", ball_x, saved_bx);
    chk("frozen_y", ball_y, saved_by);
    chk("frozen_p1", p1_y, 210);

    // Reset mid-pause
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    chk_reset_vals("rst2");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
